rx_descaper: RTL and testbench

RX_DESCAPER -- requirements
Module: rx_descaper

---
 rtl/rx_descaper_if.sv | 33 +++
 rtl/rx_descaper.sv | 147 ++++++++++++++
 tb/tb_rx_descaper.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/rx_descaper_if.sv
// Line-side word stream into the descaper and decoded stream/status out of it.
// The master side drives the escaped words and control; the slave side is the descaper.
interface rx_descaper_if #(
    parameter int UNITWIDTH  = 16,
    parameter int LANENUMBER = 4
);
    logic                  in_enable;
    logic                  in_rxdata_en;
    logic [UNITWIDTH-1:0]  in_rxdata;
    logic [2:0]            in_lane_id;
    logic                  in_clr_err;

    logic                  out_rxdata_en;
    logic [UNITWIDTH-1:0]  out_rxdata;
    logic                  out_rxsync;
    logic [LANENUMBER-1:0] out_remote_blocklock;
    logic                  out_idle;
    logic                  out_err_esc;
    logic                  out_err_lane;
    logic [7:0]            out_err_count;

    modport master (
        output in_enable, in_rxdata_en, in_rxdata, in_lane_id, in_clr_err,
        input  out_rxdata_en, out_rxdata, out_rxsync, out_remote_blocklock,
               out_idle, out_err_esc, out_err_lane, out_err_count
    );

    modport slave (
        input  in_enable, in_rxdata_en, in_rxdata, in_lane_id, in_clr_err,
        output out_rxdata_en, out_rxdata, out_rxsync, out_remote_blocklock,
               out_idle, out_err_esc, out_err_lane, out_err_count
    );
endinterface

// File: rtl/rx_descaper.sv
// Receive-side descaper: strips the escape word from the line stream and turns
// escaped pairs into data, idle, sync or error events, one registered cycle later.
module rx_descaper #(
    parameter int UNITWIDTH  = 16,
    parameter int LANENUMBER = 4,
    parameter logic [UNITWIDTH-1:0] ESC_CHAR  = 16'h5C5C,
    parameter logic [UNITWIDTH-1:0] IDLE_CHAR = 16'h0707,
    parameter logic [UNITWIDTH-LANENUMBER-8:0] SYNC_CHAR = 5'b10110
) (
    input  logic          clk,
    input  logic          reset_n,
    rx_descaper_if.slave  bus
);

    localparam int SYNC_W = UNITWIDTH - 7 - LANENUMBER;

    typedef enum logic {
        NORMAL  = 1'b0,
        GOT_ESC = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [UNITWIDTH-1:0]  rxdata_q, rxdata_d;
    logic                  rxdata_en_q, rxdata_en_d;
    logic                  rxsync_q, rxsync_d;
    logic [LANENUMBER-1:0] blocklock_q, blocklock_d;
    logic                  idle_q, idle_d;
    logic                  err_esc_q, err_esc_d;
    logic                  err_lane_q, err_lane_d;
    logic [7:0]            err_count_q, err_count_d;

    logic [UNITWIDTH-1:0]  word;
    logic                  word_is_esc;
    logic                  word_is_idle;
    logic                  word_is_sync;
    logic                  word_lane_ok;

    // Classify the incoming word; only meaningful for the second word of an escape.
    always_comb begin
        word         = bus.in_rxdata;
        word_is_esc  = (word == ESC_CHAR);
        word_is_idle = (word == IDLE_CHAR);
        word_is_sync = (word[UNITWIDTH-1 -: SYNC_W] == SYNC_CHAR) &&
                       (word[LANENUMBER+3:LANENUMBER] == 4'b0000);
        word_lane_ok = (word[LANENUMBER+6:LANENUMBER+4] == bus.in_lane_id);
    end

    // Next-state and next-output logic; everything freezes while in_enable is low.
    always_comb begin
        state_d       = state_q;
        rxdata_d      = rxdata_q;
        rxdata_en_d   = rxdata_en_q;
        rxsync_d      = rxsync_q;
        blocklock_d   = blocklock_q;
        idle_d        = idle_q;
        err_esc_d     = err_esc_q;
        err_lane_d    = err_lane_q;
        err_count_d   = err_count_q;

        if (bus.in_enable) begin
            rxdata_en_d = 1'b0;
            rxsync_d    = 1'b0;
            idle_d      = 1'b0;
            err_esc_d   = 1'b0;
            err_lane_d  = 1'b0;

            if (bus.in_rxdata_en) begin
                unique case (state_q)
                    NORMAL: begin
                        if (word_is_esc) begin
                            state_d = GOT_ESC;
                        end else begin
                            rxdata_d    = word;
                            rxdata_en_d = 1'b1;
                        end
                    end
                    GOT_ESC: begin
                        state_d = NORMAL;
                        if (word_is_esc) begin
                            rxdata_d    = ESC_CHAR;
                            rxdata_en_d = 1'b1;
                        end else if (word_is_idle) begin
                            idle_d = 1'b1;
                        end else if (word_is_sync) begin
                            rxsync_d    = 1'b1;
                            blocklock_d = word[LANENUMBER-1:0];
                            err_lane_d  = !word_lane_ok;
                        end else begin
                            err_esc_d = 1'b1;
                        end
                    end
                    default: state_d = NORMAL;
                endcase
            end

            // A clear request beats a coincident error; the counter sticks at 255.
            if (bus.in_clr_err) begin
                err_count_d = 8'd0;
            end else if ((err_esc_d || err_lane_d) && (err_count_q != 8'hFF)) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    // State and output registers, cleared asynchronously so a pending escape is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= NORMAL;
            rxdata_q    <= '0;
            rxdata_en_q <= 1'b0;
            rxsync_q    <= 1'b0;
            blocklock_q <= '0;
            idle_q      <= 1'b0;
            err_esc_q   <= 1'b0;
            err_lane_q  <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            rxdata_q    <= rxdata_d;
            rxdata_en_q <= rxdata_en_d;
            rxsync_q    <= rxsync_d;
            blocklock_q <= blocklock_d;
            idle_q      <= idle_d;
            err_esc_q   <= err_esc_d;
            err_lane_q  <= err_lane_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.out_rxdata_en        = rxdata_en_q;
    assign bus.out_rxdata           = rxdata_q;
    assign bus.out_rxsync           = rxsync_q;
    assign bus.out_remote_blocklock = blocklock_q;
    assign bus.out_idle             = idle_q;
    assign bus.out_err_esc          = err_esc_q;
    assign bus.out_err_lane         = err_lane_q;
    assign bus.out_err_count        = err_count_q;

    // Each decoded word yields at most one kind of event.
    a_one_event: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0({rxdata_en_q, idle_q, rxsync_q, err_esc_q}));

    // A lane error is only ever reported alongside its sync.
    a_lane_with_sync: assert property (@(posedge clk) disable iff (!reset_n)
        err_lane_q |-> rxsync_q);

endmodule

// File: tb/tb_rx_descaper.sv
// Self-checking bench for rx_descaper: directed scenarios followed by random
// traffic, all compared against a word-level reference model.
module tb_rx_descaper;

    localparam logic [15:0] ESC  = 16'h5C5C;
    localparam logic [15:0] IDLE = 16'h0707;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    rx_descaper_if #(.UNITWIDTH(16), .LANENUMBER(4)) bus ();

    rx_descaper #(
        .UNITWIDTH (16),
        .LANENUMBER(4),
        .ESC_CHAR  (16'h5C5C),
        .IDLE_CHAR (16'h0707),
        .SYNC_CHAR (5'b10110)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: one pending-escape flag plus the expected outputs.
    bit          mPending;
    logic [15:0] mData;
    logic [3:0]  mBlock;
    int          mCount;
    bit          mDataEn, mIdle, mSync, mErrEsc, mErrLane;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    endtask

    task automatic checkAll(input string where);
        checkOutput({where, ".data_en"},  32'(bus.out_rxdata_en),        32'(mDataEn));
        checkOutput({where, ".data"},     32'(bus.out_rxdata),           32'(mData));
        checkOutput({where, ".idle"},     32'(bus.out_idle),             32'(mIdle));
        checkOutput({where, ".sync"},     32'(bus.out_rxsync),           32'(mSync));
        checkOutput({where, ".err_esc"},  32'(bus.out_err_esc),          32'(mErrEsc));
        checkOutput({where, ".err_lane"}, 32'(bus.out_err_lane),         32'(mErrLane));
        checkOutput({where, ".blocklock"},32'(bus.out_remote_blocklock), 32'(mBlock));
        checkOutput({where, ".err_count"},32'(bus.out_err_count),        32'(mCount));
    endtask

    function automatic void modelReset();
        mPending = 0; mData = '0; mBlock = '0; mCount = 0;
        mDataEn = 0; mIdle = 0; mSync = 0; mErrEsc = 0; mErrLane = 0;
    endfunction

    // Decode one clock edge worth of input at the level of whole words.
    function automatic void modelStep(input bit en, input bit valid, input logic [15:0] w,
                                      input logic [2:0] lane, input bit clr);
        int tag, mid, laneField;
        if (!en) return;
        mDataEn = 0; mIdle = 0; mSync = 0; mErrEsc = 0; mErrLane = 0;
        tag       = int'(w) / 2048;
        laneField = (int'(w) / 256) % 8;
        mid       = (int'(w) / 16) % 16;
        if (valid) begin
            if (!mPending) begin
                if (w == ESC) mPending = 1;
                else begin mDataEn = 1; mData = w; end
            end else begin
                mPending = 0;
                if (w == ESC) begin mDataEn = 1; mData = ESC; end
                else if (w == IDLE) mIdle = 1;
                else if (tag == 22 && mid == 0) begin
                    mSync    = 1;
                    mBlock   = 4'(int'(w) % 16);
                    mErrLane = (laneField != int'(lane));
                end else mErrEsc = 1;
            end
        end
        if (clr) mCount = 0;
        else if ((mErrEsc || mErrLane) && mCount < 255) mCount++;
    endfunction

    // Drive one cycle of input, let the edge happen, then compare just after it.
    task automatic applyStimulus(input bit en, input bit valid, input logic [15:0] w,
                                 input logic [2:0] lane, input bit clr, input string tag);
        bus.in_enable    = en;
        bus.in_rxdata_en = valid;
        bus.in_rxdata    = w;
        bus.in_lane_id   = lane;
        bus.in_clr_err   = clr;
        @(posedge clk);
        modelStep(en, valid, w, lane, clr);
        #1;
        checkAll(tag);
    endtask

    task automatic sendWord(input logic [15:0] w, input logic [2:0] lane, input string tag);
        applyStimulus(1'b1, 1'b1, w, lane, 1'b0, tag);
    endtask

    // Pulse the asynchronous reset between clock edges.
    task automatic doReset(input string tag);
        reset_n = 1'b0;
        #1;
        modelReset();
        checkAll(tag);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [15:0] w;
        logic [2:0]  lane;
        int          pick;

        reset_n          = 1'b0;
        bus.in_enable    = 1'b0;
        bus.in_rxdata_en = 1'b0;
        bus.in_rxdata    = '0;
        bus.in_lane_id   = 3'd2;
        bus.in_clr_err   = 1'b0;
        #1;
        modelReset();
        checkAll("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Plain data words and enable-low hold.
        sendWord(16'h1234, 3'd2, "d1");
        checkOutput("d1_literal", 32'(bus.out_rxdata), 32'h1234);
        sendWord(16'hABCD, 3'd2, "d2");
        checkOutput("d2_literal", 32'(bus.out_rxdata), 32'hABCD);
        applyStimulus(1'b0, 1'b1, 16'h5555, 3'd2, 1'b0, "hold");
        applyStimulus(1'b1, 1'b0, 16'h5555, 3'd2, 1'b0, "gap");

        // Escaped escape then escaped idle.
        sendWord(ESC, 3'd2, "ee1");
        sendWord(ESC, 3'd2, "ee2");
        checkOutput("ee_literal", 32'(bus.out_rxdata), 32'h5C5C);
        sendWord(ESC, 3'd2, "ei1");
        sendWord(IDLE, 3'd2, "ei2");
        checkOutput("ei_literal", 32'(bus.out_idle), 32'd1);

        // Sync with matching and mismatching lane id.
        sendWord(ESC, 3'd2, "s1a");
        sendWord(16'hB20B, 3'd2, "s1b");
        checkOutput("s1_block", 32'(bus.out_remote_blocklock), 32'hB);
        sendWord(ESC, 3'd5, "s2a");
        sendWord(16'hB205, 3'd5, "s2b");
        checkOutput("s2_lane", 32'(bus.out_err_lane), 32'd1);
        checkOutput("s2_count", 32'(bus.out_err_count), 32'd1);

        // Illegal escape across an invalid-cycle gap.
        sendWord(ESC, 3'd2, "ie1");
        applyStimulus(1'b1, 1'b0, 16'h0000, 3'd2, 1'b0, "ie_gap");
        sendWord(16'h0001, 3'd2, "ie2");
        checkOutput("ie_err", 32'(bus.out_err_esc), 32'd1);
        sendWord(16'h0002, 3'd2, "ie3");

        // Saturation, then clear, then clear colliding with an error.
        for (int i = 0; i < 300; i++) begin
            sendWord(ESC, 3'd2, "sat_a");
            sendWord(16'h0001, 3'd2, "sat_b");
        end
        checkOutput("sat_count", 32'(bus.out_err_count), 32'd255);
        applyStimulus(1'b1, 1'b0, 16'h0000, 3'd2, 1'b1, "clr");
        checkOutput("clr_count", 32'(bus.out_err_count), 32'd0);
        sendWord(ESC, 3'd2, "clrx_a");
        applyStimulus(1'b1, 1'b1, 16'h0001, 3'd2, 1'b1, "clrx_b");
        checkOutput("clrx_count", 32'(bus.out_err_count), 32'd0);

        // Reset between ESC and IDLE drops the escape.
        sendWord(ESC, 3'd2, "r_esc");
        doReset("r_mid");
        sendWord(IDLE, 3'd2, "r_idle");
        checkOutput("r_no_idle", 32'(bus.out_idle), 32'd0);
        sendWord(ESC, 3'd2, "r_esc2");
        sendWord(IDLE, 3'd2, "r_idle2");

        // Random traffic biased toward escape-related words.
        for (int i = 0; i < 3000; i++) begin
            lane = 3'($urandom_range(0, 7));
            pick = $urandom_range(0, 99);
            if (pick < 30) w = ESC;
            else if (pick < 45) w = IDLE;
            else if (pick < 60) begin
                w = {5'b10110, ($urandom_range(0, 1) == 0) ? lane : 3'($urandom_range(0, 7)),
                     4'b0000, 4'($urandom_range(0, 15))};
            end else if (pick < 65) w = {5'b10110, 3'($urandom_range(0, 7)),
                                         4'($urandom_range(1, 15)), 4'($urandom_range(0, 15))};
            else w = 16'($urandom());
            if ($urandom_range(0, 499) == 0) doReset("rnd_reset");
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 8, w, lane,
                          $urandom_range(0, 49) == 0, "rnd");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
